// File: rtl/rca_pipe_nbit_if.sv
// Operand/result handshake bundle for the pipelined ripple-carry adder.
// The producer/consumer side uses the master modport, the adder uses slave.
interface rca_pipe_nbit_if #(
    parameter int N = 34
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] s;
    logic         cout;
    logic         ovf;

    modport master (
        output in_valid, x, y, cin, sub, out_ready,
        input  in_ready, out_valid, s, cout, ovf
    );

    modport slave (
        input  in_valid, x, y, cin, sub, out_ready,
        output in_ready, out_valid, s, cout, ovf
    );
endinterface

// File: rtl/rca_pipe_nbit.sv
// Pipelined N-bit add/subtract built from K-bit ripple chunks, one chunk per
// stage. Each stage carries the low sum bits produced so far plus only the
// operand bits that later stages still need, so every stored bit is consumed.
// The whole pipeline advances together; a stalled output freezes every stage.
module rca_pipe_nbit #(
    parameter int N = 34,
    parameter int K = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    rca_pipe_nbit_if.slave io
);
    localparam int S = (N + K - 1) / K;

    logic         en;
    logic [N-1:0] y_inv;

    // Single global enable: advance whenever the output slot is free or draining.
    assign en          = !io.out_valid || io.out_ready;
    assign io.in_ready = en;

    // Subtract is x + ~y + ~borrow; inverting cin as well keeps cin a borrow-in.
    assign y_inv = io.y ^ {N{io.sub}};

    for (genvar i = 0; i < S; i++) begin : g_stage
        localparam int LO = i * K;
        localparam int W  = (i == S - 1) ? (N - LO) : K;
        localparam int HI = LO + W;

        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic          c_in;
        logic          v_in;
        logic [W:0]    chunk;
        logic [HI-1:0] s_next;

        logic          v_q;
        logic          c_q;
        logic [HI-1:0] s_q;

        if (i == 0) begin : g_src
            assign a      = io.x[W-1:0];
            assign b      = y_inv[W-1:0];
            assign c_in   = io.cin ^ io.sub;
            assign v_in   = io.in_valid;
            assign s_next = chunk[W-1:0];
        end else begin : g_src
            assign a      = g_stage[i-1].g_hi.xh_q[W-1:0];
            assign b      = g_stage[i-1].g_hi.yh_q[W-1:0];
            assign c_in   = g_stage[i-1].c_q;
            assign v_in   = g_stage[i-1].v_q;
            assign s_next = {chunk[W-1:0], g_stage[i-1].s_q};
        end

        assign chunk = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c_in};

        // Chunk result, ripple carry and valid advance together on enable.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (en) begin
                v_q <= v_in;
                c_q <= chunk[W];
                s_q <= s_next;
            end
        end

        if (i < S - 1) begin : g_hi
            logic [N-HI-1:0] xh_d;
            logic [N-HI-1:0] yh_d;
            logic [N-HI-1:0] xh_q;
            logic [N-HI-1:0] yh_q;

            if (i == 0) begin : g_hd
                assign xh_d = io.x[N-1:HI];
                assign yh_d = y_inv[N-1:HI];
            end else begin : g_hd
                assign xh_d = g_stage[i-1].g_hi.xh_q[N-LO-1:W];
                assign yh_d = g_stage[i-1].g_hi.yh_q[N-LO-1:W];
            end

            // Unprocessed upper operand bits ride along to the later stages.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    xh_q <= '0;
                    yh_q <= '0;
                end else if (en) begin
                    xh_q <= xh_d;
                    yh_q <= yh_d;
                end
            end
        end

        if (i == S - 1) begin : g_ovf
            logic ovf_q;

            // Carry into the MSB is recovered from the MSB sum bit and its operands.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (en) begin
                    ovf_q <= chunk[W] ^ (chunk[W-1] ^ a[W-1] ^ b[W-1]);
                end
            end
        end
    end

    assign io.out_valid = g_stage[S-1].v_q;
    assign io.s         = g_stage[S-1].s_q;
    assign io.cout      = g_stage[S-1].c_q;
    assign io.ovf       = g_stage[S-1].g_ovf.ovf_q;

endmodule

// File: doc/rca_pipe_nbit.md
Name: rca_pipe_nbit

Overview:
- Pipelined, parametrised successor to the team's combinational n-bit ripple-carry adder.
- Splits an N-bit add/subtract into K-bit chunks, with one chunk ripple per pipeline stage, so wide adders (34 bits and up) meet timing.
- Adds subtract mode, a signed-overflow flag, and a valid/ready handshake with full-pipeline backpressure.
- Sits between operand producers and accumulators/ALU datapaths; one instance per channel.

Parameters:
- N, 34, operand and sum width in bits (N >= 2).
- K, 8, chunk width per pipeline stage (1 <= K). Number of stages S = ceil(N/K); the top chunk is N-(S-1)*K bits wide.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and mode presented this cycle.
- in_ready  output  1  block accepts operands this cycle.
- x  input  N  operand A.
- y  input  N  operand B.
- cin  input  1  carry-in (borrow-in when sub=1).
- sub  input  1  0: s = x + y + cin. 1: s = x + ~y + ~cin, i.e. x - y - cin.
- out_valid  output  1  s/cout/ovf valid.
- out_ready  input  1  consumer accepts result this cycle.
- s  output  N  sum/difference, modulo 2^N.
- cout  output  1  carry out of bit N-1. When sub=1, cout=1 means no borrow.
- ovf  output  1  two's-complement overflow: carry into bit N-1 XOR carry out of bit N-1.

Behaviour:
- Transfer rules:
  - Input transfer occurs when in_valid and in_ready are both high.
  - Output transfer occurs when out_valid and out_ready are both high.
- Pipeline enable: en = !out_valid || out_ready. in_ready = en (combinational). All stage registers, including valid bits, load only when en=1. When en=0, every stage holds.
- Stage 0:
  - Captures y' = y ^ {N{sub}} and c' = cin ^ sub.
  - Computes chunk 0: x[K-1:0] + y'[K-1:0] + c'.
  - Registers the chunk-0 sum bits, the chunk carry, the untouched upper x/y' bits and a valid bit (in_valid at capture).
- Stage i (1..S-1):
  - Adds chunk i of the delayed x/y' plus the registered carry from stage i-1.
  - Passes along the lower sum bits already produced and the still-unprocessed upper operand bits.
  - The last stage also records the carry into its top bit for ovf.
- Latency: exactly S cycles from input transfer to out_valid, with no stalls. Each stall cycle (en=0) adds one cycle. Throughput is one result per cycle while out_ready=1.
- Outputs are driven directly from last-stage registers (no combinational path from x/y to s).
- Bubbles: a stage loaded with valid=0 carries don't-care data. out_valid=0 for such a slot. s/cout/ovf must still be deterministic (registers load whatever is presented).
- Ordering: results emerge in input order. No drop and no duplication under any out_ready pattern.
- Degenerate K >= N: S=1, single registered stage, latency 1.
- Reset (rst_n=0, asynchronous, any time including mid-stream):
  - All valid bits clear immediately and in-flight operations are discarded.
  - out_valid=0, s=0, cout=0, ovf=0.
  - in_ready=1 after reset, since en=1 when out_valid=0.
  - No result is produced for operations accepted before reset.
- Simultaneous input and output transfer in the same cycle is normal pipelined operation: the pipeline shifts by one.
- in_valid while in_ready=0: operands are ignored. The producer must hold them; the block does not latch them.

Test Plan:
- N=34, K=8 (S=5): x=0x3_FFFF_FFFF, y=1, cin=0, sub=0, out_ready=1 -> 5 cycles later out_valid=1, s=0, cout=1, ovf=0.
- N=34, K=8: x=5, y=7, cin=0, sub=1 -> s=0x3_FFFF_FFFE, cout=0 (borrow), ovf=0. Then x=7, y=5 -> s=2, cout=1.
- N=34, K=8: x=0x1_FFFF_FFFF, y=1, sub=0 -> s=0x2_0000_0000, ovf=1, cout=0. Then x=0x2_0000_0000, y=1, sub=1 -> s=0x1_FFFF_FFFF, ovf=1.
- Backpressure: stream 8 back-to-back adds (x=i, y=100*i) and hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 during the stall, all 8 results s=101*i emerge in order with no loss or duplication.
- Reset mid-operation: accept 3 ops, assert rst_n=0 for 1 cycle while they are in flight -> out_valid, s, cout and ovf go to 0 immediately, none of the 3 results ever appears, in_ready=1 after release.
- Degenerate N=16, K=16: x=0xFFFF, y=0x0001, cin=1 -> latency 1, s=0x0001, cout=1.
